// File: rtl/blft_param.sv
// Parametrised bilateral filter: K x K range/spatial weighted window over a 2^ROW_BITS x 2^COL_BITS
// 8-bit image, edge-clamped reads through a combinational memory port, sequential 8-step divider.
module blft_param #(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8,
  parameter int RADIUS   = 2,
  parameter int WBITS    = 6,
  parameter int RSHIFT   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         bypass,
  output logic [ROW_BITS+COL_BITS-1:0] in_addr,
  output logic                         out_valid,
  output logic [ROW_BITS+COL_BITS-1:0] out_addr,
  output logic [7:0]                   out_data,
  output logic                         finish
);
  localparam int AW      = ROW_BITS + COL_BITS;
  localparam int K       = 2 * RADIUS + 1;
  localparam int KK      = K * K;
  localparam int KW      = $clog2(K);
  localparam int SW      = WBITS + $clog2(KK);
  localparam int SWP     = SW + 8;
  localparam int ROW_MAX = (1 << ROW_BITS) - 1;
  localparam int COL_MAX = (1 << COL_BITS) - 1;
  localparam logic [WBITS-1:0] WMAX = '1;

  typedef enum logic [2:0] {IDLE, CENTER, ACC, DIV, OUT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [AW-1:0]    pix_reg, pix_next;
  logic [KW-1:0]    wy_reg, wy_next, wx_reg, wx_next;
  logic [7:0]       c_reg, c_next;
  logic [SW-1:0]    sum_w_reg, sum_w_next;
  logic [SWP-1:0]   sum_wp_reg, sum_wp_next;
  logic [SWP-1:0]   rem_reg, rem_next, den_reg, den_next;
  logic [6:0]       q_reg, q_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic [AW-1:0]    in_addr_reg, in_addr_next, out_addr_reg, out_addr_next;
  logic             out_valid_reg, out_valid_next, finish_reg, finish_next;
  logic [7:0]       out_data_reg, out_data_next;

  function automatic logic [AW-1:0] win_addr(input logic [AW-1:0] pix,
                                             input logic [KW-1:0] oy, input logic [KW-1:0] ox);
    int r, c;
    r = int'(pix[AW-1:COL_BITS]) + int'(oy) - RADIUS;
    c = int'(pix[COL_BITS-1:0]) + int'(ox) - RADIUS;
    if (r < 0) r = 0; else if (r > ROW_MAX) r = ROW_MAX;
    if (c < 0) c = 0; else if (c > COL_MAX) c = COL_MAX;
    return {r[ROW_BITS-1:0], c[COL_BITS-1:0]};
  endfunction

  // Weight of the pixel currently on in_data for window position (wy_reg, wx_reg).
  logic [7:0]         diff;
  logic [WBITS+7:0]   dsh;
  logic [WBITS-1:0]   rw, w;
  logic [WBITS+7:0]   wp;
  logic [SW-1:0]      acc_w;
  logic [SWP-1:0]     acc_wp;
  logic               near, last_read, ge;
  logic [KW-1:0]      nwy, nwx;
  logic [AW-1:0]      pix_inc, centre_next;
  int                 dya, dxa;

  always_comb begin
    diff = (in_data >= c_reg) ? in_data - c_reg : c_reg - in_data;
    dsh  = (WBITS+8)'(diff >> RSHIFT);
    rw   = (dsh >= (WBITS+8)'(WMAX)) ? '0 : WMAX - dsh[WBITS-1:0];
    dya  = int'(wy_reg) - RADIUS;
    dxa  = int'(wx_reg) - RADIUS;
    if (dya < 0) dya = -dya;
    if (dxa < 0) dxa = -dxa;
    near   = (dya + dxa) <= RADIUS;
    w      = near ? rw : rw >> 1;
    wp     = w * in_data;
    acc_w  = sum_w_reg + SW'(w);
    acc_wp = sum_wp_reg + SWP'(wp);
    last_read = (wy_reg == KW'(K-1)) && (wx_reg == KW'(K-1));
    if (wx_reg == KW'(K-1)) begin
      nwy = wy_reg + 1'b1;
      nwx = '0;
    end else begin
      nwy = wy_reg;
      nwx = wx_reg + 1'b1;
    end
    ge      = rem_reg >= den_reg;
    pix_inc = pix_reg + 1'b1;
    // After the final pixel the address simply stays where the last read left it.
    centre_next = (&pix_reg) ? pix_reg : pix_inc;
  end

  always_comb begin
    state_next     = state_reg;
    pix_next       = pix_reg;
    wy_next        = wy_reg;
    wx_next        = wx_reg;
    c_next         = c_reg;
    sum_w_next     = sum_w_reg;
    sum_wp_next    = sum_wp_reg;
    rem_next       = rem_reg;
    den_next       = den_reg;
    q_next         = q_reg;
    cnt_next       = cnt_reg;
    in_addr_next   = in_addr_reg;
    out_valid_next = 1'b0;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    finish_next    = finish_reg;
    unique case (state_reg)
      IDLE: state_next = CENTER;
      CENTER: begin
        sum_w_next  = '0;
        sum_wp_next = '0;
        if (in_valid) begin
          c_next = in_data;
          if (bypass) begin
            state_next     = OUT;
            out_valid_next = 1'b1;
            out_addr_next  = pix_reg;
            out_data_next  = in_data;
            in_addr_next   = centre_next;
          end else begin
            state_next   = ACC;
            wy_next      = '0;
            wx_next      = '0;
            in_addr_next = win_addr(pix_reg, '0, '0);
          end
        end
      end
      ACC: if (in_valid) begin
        sum_w_next  = acc_w;
        sum_wp_next = acc_wp;
        if (last_read) begin
          // Rounding bias folded into the dividend; divisor pre-aligned to quotient bit 7.
          state_next   = DIV;
          rem_next     = acc_wp + SWP'(acc_w >> 1);
          den_next     = SWP'(acc_w) << 7;
          q_next       = '0;
          cnt_next     = '0;
          in_addr_next = centre_next;
        end else begin
          wy_next      = nwy;
          wx_next      = nwx;
          in_addr_next = win_addr(pix_reg, nwy, nwx);
        end
      end
      DIV: begin
        rem_next = ge ? rem_reg - den_reg : rem_reg;
        den_next = den_reg >> 1;
        q_next   = {q_reg[5:0], ge};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == 3'd7) begin
          state_next     = OUT;
          out_valid_next = 1'b1;
          out_addr_next  = pix_reg;
          out_data_next  = {q_reg, ge};
        end
      end
      OUT: begin
        if (&pix_reg) begin
          state_next  = DONE;
          finish_next = 1'b1;
        end else begin
          pix_next   = pix_inc;
          state_next = CENTER;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pix_reg       <= '0;
      wy_reg        <= '0;
      wx_reg        <= '0;
      c_reg         <= '0;
      sum_w_reg     <= '0;
      sum_wp_reg    <= '0;
      rem_reg       <= '0;
      den_reg       <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
      in_addr_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      finish_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pix_reg       <= pix_next;
      wy_reg        <= wy_next;
      wx_reg        <= wx_next;
      c_reg         <= c_next;
      sum_w_reg     <= sum_w_next;
      sum_wp_reg    <= sum_wp_next;
      rem_reg       <= rem_next;
      den_reg       <= den_next;
      q_reg         <= q_next;
      cnt_reg       <= cnt_next;
      in_addr_reg   <= in_addr_next;
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      finish_reg    <= finish_next;
    end
  end

  assign in_addr   = in_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign finish    = finish_reg;
endmodule

// File: tb/tb_blft_param.sv
// Bench for blft_param on a 16x8 image: directed scenarios, reference model of values and cycle timing.
module tb_blft_param;
  localparam int CB = 4, RB = 3, R = 2, WB = 6, RS = 3;
  localparam int W = 1 << CB, H = 1 << RB, N = W * H, K = 2 * R + 1;
  localparam int WMAX = (1 << WB) - 1;
  localparam int MAXE = 16384;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, bypass = 1'b0;
  logic [7:0] in_data, out_data;
  logic [RB+CB-1:0] in_addr, out_addr;
  logic out_valid, finish;
  logic [7:0] img [0:N-1];

  int checks = 0, errors = 0;
  int exp_px [N];
  int dut_px [N];
  bit vld    [MAXE];
  bit rd_chk [MAXE];
  int rd_exp [MAXE];
  int out_at [MAXE];

  always #5 clk = ~clk;
  assign in_data = img[in_addr];

  blft_param #(.COL_BITS(CB), .ROW_BITS(RB), .RADIUS(R), .WBITS(WB), .RSHIFT(RS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .bypass(bypass),
    .in_addr(in_addr), .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .finish(finish));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int clampi(int v, int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // Filter output straight from the weighting rules.
  function automatic int ref_px(int r, int c, bit byp);
    int cv, sw, swp, p, d, ds, rw, w, man;
    cv = int'(img[r*W + c]);
    if (byp) return cv;
    sw = 0; swp = 0;
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        p   = int'(img[clampi(r+dy, H-1)*W + clampi(c+dx, W-1)]);
        d   = (p > cv) ? p - cv : cv - p;
        ds  = d >> RS;
        rw  = WMAX - ((ds < WMAX) ? ds : WMAX);
        man = ((dx < 0) ? -dx : dx) + ((dy < 0) ? -dy : dy);
        w   = (man <= R) ? rw : rw / 2;
        sw  += w;
        swp += w * p;
      end
    end
    return (swp + sw / 2) / sw;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_addr"}, out_addr, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
  endtask

  // Plans the expected read/output timeline from accepted-read counts, then runs the image.
  task automatic run_img(input bit byp, input bit rnd, input int abort_pix);
    int e, fin, abort_e, k, a, r, c;
    for (int i = 0; i < MAXE; i++) begin
      vld[i]    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_chk[i] = 1'b0;
      rd_exp[i] = 0;
      out_at[i] = -1;
    end
    abort_e = -1;
    e = 1;
    for (int p = 0; p < N; p++) begin
      r = p / W;
      c = p % W;
      exp_px[p] = ref_px(r, c, byp);
      dut_px[p] = -1;
      for (int j = -1; j < (byp ? 0 : K*K); j++) begin
        a = (j < 0) ? p : clampi(r + j/K - R, H-1)*W + clampi(c + j%K - R, W-1);
        do begin
          e++;
          rd_chk[e] = 1'b1;
          rd_exp[e] = a;
        end while (!vld[e]);
        if (p == abort_pix && j == (K*K)/2) abort_e = e;
      end
      if (!byp) e += 8;
      out_at[e] = p;
      e++;
    end
    fin = e;

    bypass = byp;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset");
    rst = 1'b0;
    k = 1;
    while (k <= fin + 2) begin
      if (k == abort_e) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk_zero("abort");
        rst = 1'b0;
        abort_e = -1;
        k = 1;
        continue;
      end
      in_valid = vld[k];
      if (rd_chk[k]) chk("in_addr", in_addr, rd_exp[k]);
      @(posedge clk); #1;
      chk("out_valid", out_valid, out_at[k] >= 0);
      if (out_at[k] >= 0) begin
        chk("out_addr", out_addr, out_at[k]);
        chk("out_data", out_data, exp_px[out_at[k]]);
        dut_px[out_at[k]] = int'(out_data);
      end
      chk("finish", finish, k >= fin);
      k++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) img[i] = 8'd100;
    run_img(1'b0, 1'b0, -1);
    chk("const_first", dut_px[0], 100);
    chk("const_last", dut_px[N-1], 100);

    for (int i = 0; i < N; i++) img[i] = ((i % W) < W/2) ? 8'd0 : 8'd200;
    run_img(1'b0, 1'b0, -1);
    chk("step_edge", dut_px[2*W + W/2 - 1], 52);

    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
    run_img(1'b1, 1'b0, -1);

    for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(60, 160));
    run_img(1'b0, 1'b1, -1);

    run_img(1'b0, 1'b0, 3*W + 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
